// File: rtl/led_frame_buffer_wb_slave.sv
// Wishbone responder holding LED frame words in a local RAM, with a local fill
// port that takes priority over Wishbone writes and a sticky out-of-range flag.
module led_frame_buffer_wb_slave #(
  parameter  int          ADDR_WIDTH  = 16,
  parameter  int          DATA_WIDTH  = 32,
  parameter  int          DEPTH_WORDS = 256,
  parameter  int unsigned BASE_ADDR   = 0,
  localparam int          IDX_WIDTH   = $clog2(DEPTH_WORDS),
  localparam int          BSHIFT      = $clog2(DATA_WIDTH / 8)
) (
  input  logic                  reset,
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] wbs_address,
  input  logic [DATA_WIDTH-1:0] wbs_writedata,
  output logic [DATA_WIDTH-1:0] wbs_readdata,
  input  logic                  wbs_strobe,
  input  logic                  wbs_cycle,
  input  logic                  wbs_write,
  output logic                  wbs_ack,
  input  logic                  fill_we,
  input  logic [IDX_WIDTH-1:0]  fill_addr,
  input  logic [DATA_WIDTH-1:0] fill_data,
  output logic                  oor_flag,
  input  logic                  oor_clear
);

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_ACK} state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE_L  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH_WORDS);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ack_q, ack_d;
  logic                  oor_q, oor_d;
  logic                  ram_we;
  logic                  oor_set;

  logic [ADDR_WIDTH-1:0] byte_off;
  logic [ADDR_WIDTH-1:0] word_off;
  logic                  in_range;

  // The base check guards against the subtraction wrapping for addresses below BASE_ADDR.
  assign byte_off = wbs_address - BASE_L;
  assign word_off = byte_off >> BSHIFT;
  assign in_range = (wbs_address >= BASE_L) && ({1'b0, word_off} < DEPTH_L);

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ram_we  = 1'b0;
    oor_set = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (wbs_cycle && wbs_strobe) begin
          if (!in_range) begin
            state_d = ST_ACK;
            rdata_d = '0;
            oor_set = 1'b1;
          end else begin
            idx_d = word_off[IDX_WIDTH-1:0];
            if (wbs_write) begin
              state_d = ST_WR;
              wdata_d = wbs_writedata;
            end else begin
              state_d = ST_RD;
            end
          end
        end
      end
      ST_RD: begin
        if (!wbs_cycle) begin
          state_d = ST_IDLE;
        end else begin
          rdata_d = mem[idx_q];
          state_d = ST_ACK;
        end
      end
      ST_WR: begin
        if (!wbs_cycle) begin
          state_d = ST_IDLE;
        end else if (!fill_we) begin
          ram_we  = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ack_d = (state_d == ST_ACK);
    oor_d = oor_set ? 1'b1 : (oor_clear ? 1'b0 : oor_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      oor_q   <= oor_d;
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[fill_addr] <= fill_data;
    end
    if (ram_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign wbs_readdata = rdata_q;
  assign wbs_ack      = ack_q;
  assign oor_flag     = oor_q;

endmodule

// File: tb/tb_led_frame_buffer_wb_slave.sv
// Directed bench for led_frame_buffer_wb_slave: a vector table of single
// transfers plus hand-written sequences for stalls, aborts, collisions and reset.
module tb_led_frame_buffer_wb_slave;

  logic        reset;
  logic        clk;
  logic [15:0] wbs_address;
  logic [31:0] wbs_writedata;
  logic [31:0] wbs_readdata;
  logic        wbs_strobe;
  logic        wbs_cycle;
  logic        wbs_write;
  logic        wbs_ack;
  logic        fill_we;
  logic [7:0]  fill_addr;
  logic [31:0] fill_data;
  logic        oor_flag;
  logic        oor_clear;

  int errors = 0;
  int checks = 0;

  led_frame_buffer_wb_slave dut (
    .reset         (reset),
    .clk           (clk),
    .wbs_address   (wbs_address),
    .wbs_writedata (wbs_writedata),
    .wbs_readdata  (wbs_readdata),
    .wbs_strobe    (wbs_strobe),
    .wbs_cycle     (wbs_cycle),
    .wbs_write     (wbs_write),
    .wbs_ack       (wbs_ack),
    .fill_we       (fill_we),
    .fill_addr     (fill_addr),
    .fill_data     (fill_data),
    .oor_flag      (oor_flag),
    .oor_clear     (oor_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
    logic        exp_oor;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One Wishbone transfer; lat counts edges from the first sampling edge to ack (-1 on timeout).
  task automatic wb_xfer(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata);
    @(posedge clk); #1;
    wbs_cycle = 1'b1; wbs_strobe = 1'b1; wbs_write = we;
    wbs_address = addr; wbs_writedata = wdata;
    lat = -1;
    rdata = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (wbs_ack) begin
        lat = c;
        rdata = wbs_readdata;
        break;
      end
    end
    wbs_cycle = 1'b0; wbs_strobe = 1'b0; wbs_write = 1'b0;
    @(posedge clk); #1;
    check("ack_one_cycle", 32'(wbs_ack), 32'd0);
  endtask

  task automatic fill_word(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    fill_we = 1'b1; fill_addr = a; fill_data = d;
    @(posedge clk); #1;
    fill_we = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        saw_ack;

    vecs[0]  = '{1'b0, 16'h0014, 32'h0,         32'hA5A5_0001, 2, 1'b0};
    vecs[1]  = '{1'b1, 16'h0020, 32'h1234_5678, 32'hA5A5_0001, 2, 1'b0};
    vecs[2]  = '{1'b0, 16'h0020, 32'h0,         32'h1234_5678, 2, 1'b0};
    vecs[3]  = '{1'b0, 16'h0017, 32'h0,         32'hA5A5_0001, 2, 1'b0};
    vecs[4]  = '{1'b0, 16'h03FC, 32'h0,         32'hC0DE_00FF, 2, 1'b0};
    vecs[5]  = '{1'b1, 16'h03FC, 32'hDEAD_BEEF, 32'hC0DE_00FF, 2, 1'b0};
    vecs[6]  = '{1'b0, 16'h03FC, 32'h0,         32'hDEAD_BEEF, 2, 1'b0};
    vecs[7]  = '{1'b0, 16'h0400, 32'h0,         32'h0,         1, 1'b1};
    vecs[8]  = '{1'b1, 16'h0404, 32'hBAD0_0001, 32'h0,         1, 1'b1};
    vecs[9]  = '{1'b0, 16'h0000, 32'h0,         32'hC0DE_0000, 2, 1'b1};
    vecs[10] = '{1'b0, 16'h0004, 32'h0,         32'hC0DE_0001, 2, 1'b1};

    reset = 1'b1;
    wbs_address = '0; wbs_writedata = '0;
    wbs_strobe = 1'b0; wbs_cycle = 1'b0; wbs_write = 1'b0;
    fill_we = 1'b0; fill_addr = '0; fill_data = '0; oor_clear = 1'b0;
    #23;
    check("reset_ack", 32'(wbs_ack), 32'd0);
    check("reset_readdata", wbs_readdata, 32'd0);
    check("reset_oor", 32'(oor_flag), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Known background pattern, then the word under test at index 5
    @(posedge clk); #1;
    fill_we = 1'b1;
    for (int i = 0; i < 256; i++) begin
      fill_addr = 8'(i); fill_data = 32'hC0DE_0000 | 32'(i);
      @(posedge clk); #1;
    end
    fill_we = 1'b0;
    fill_word(8'd5, 32'hA5A5_0001);

    for (int v = 0; v < 11; v++) begin
      wb_xfer(vecs[v].we, vecs[v].addr, vecs[v].wdata, lat, rd);
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      check($sformatf("vec%0d_readdata", v), rd, vecs[v].exp_rd);
      check($sformatf("vec%0d_oor", v), 32'(oor_flag), 32'(vecs[v].exp_oor));
    end

    // oor_clear pulse, then clear and a new out-of-range event in the same cycle
    @(posedge clk); #1; oor_clear = 1'b1;
    @(posedge clk); #1; oor_clear = 1'b0;
    check("oor_cleared", 32'(oor_flag), 32'd0);
    wbs_cycle = 1'b1; wbs_strobe = 1'b1; wbs_write = 1'b0; wbs_address = 16'h0800;
    oor_clear = 1'b1;
    @(posedge clk); #1;
    oor_clear = 1'b0; wbs_cycle = 1'b0; wbs_strobe = 1'b0;
    check("oor_set_wins", 32'(oor_flag), 32'd1);
    check("oor_ack_lat1", 32'(wbs_ack), 32'd1);
    @(posedge clk); #1; oor_clear = 1'b1;
    @(posedge clk); #1; oor_clear = 1'b0;
    check("oor_cleared_again", 32'(oor_flag), 32'd0);

    // Write to idx 3 held off by three cycles of fill traffic at idx 9
    @(posedge clk); #1;
    wbs_cycle = 1'b1; wbs_strobe = 1'b1; wbs_write = 1'b1;
    wbs_address = 16'h000C; wbs_writedata = 32'h3333_3333;
    @(posedge clk); #1;
    fill_we = 1'b1; fill_addr = 8'd9; fill_data = 32'h9999_9999;
    lat = -1;
    for (int c = 2; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 4) fill_we = 1'b0;
      if (wbs_ack) begin
        lat = c;
        break;
      end
    end
    fill_we = 1'b0;
    wbs_cycle = 1'b0; wbs_strobe = 1'b0; wbs_write = 1'b0;
    check("stall_write_latency", 32'(lat), 32'd5);
    @(posedge clk); #1;
    check("stall_ack_one_cycle", 32'(wbs_ack), 32'd0);
    wb_xfer(1'b0, 16'h000C, 32'h0, lat, rd);
    check("stall_ram3", rd, 32'h3333_3333);
    wb_xfer(1'b0, 16'h0024, 32'h0, lat, rd);
    check("stall_ram9", rd, 32'h9999_9999);

    // Abort a write that is being held in ST_WR by fill traffic
    @(posedge clk); #1;
    wbs_cycle = 1'b1; wbs_strobe = 1'b1; wbs_write = 1'b1;
    wbs_address = 16'h0010; wbs_writedata = 32'h4444_4444;
    @(posedge clk); #1;
    fill_we = 1'b1; fill_addr = 8'd20; fill_data = 32'h2020_2020;
    @(posedge clk); #1;
    fill_we = 1'b0;
    wbs_cycle = 1'b0; wbs_strobe = 1'b0; wbs_write = 1'b0;
    saw_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (wbs_ack) saw_ack = 1'b1;
    end
    check("abort_no_ack", 32'(saw_ack), 32'd0);
    wb_xfer(1'b0, 16'h0010, 32'h0, lat, rd);
    check("abort_idle_latency", 32'(lat), 32'd2);
    check("abort_ram_unchanged", rd, 32'hC0DE_0004);
    wb_xfer(1'b0, 16'h0050, 32'h0, lat, rd);
    check("abort_fill_landed", rd, 32'h2020_2020);

    // Fill to idx 7 on the same edge the read of idx 7 samples the RAM
    @(posedge clk); #1;
    wbs_cycle = 1'b1; wbs_strobe = 1'b1; wbs_write = 1'b0; wbs_address = 16'h001C;
    @(posedge clk); #1;
    fill_we = 1'b1; fill_addr = 8'd7; fill_data = 32'h7777_0007;
    @(posedge clk); #1;
    fill_we = 1'b0;
    wbs_cycle = 1'b0; wbs_strobe = 1'b0;
    check("rbw_ack", 32'(wbs_ack), 32'd1);
    check("rbw_old_word", wbs_readdata, 32'hC0DE_0007);
    wb_xfer(1'b0, 16'h001C, 32'h0, lat, rd);
    check("rbw_new_word", rd, 32'h7777_0007);

    // Reset asserted while a read is in ST_RD
    @(posedge clk); #1;
    wbs_cycle = 1'b1; wbs_strobe = 1'b1; wbs_write = 1'b0; wbs_address = 16'h0014;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midreset_ack", 32'(wbs_ack), 32'd0);
    check("midreset_readdata", wbs_readdata, 32'd0);
    wbs_cycle = 1'b0; wbs_strobe = 1'b0;
    @(posedge clk); #1;
    check("midreset_no_ack", 32'(wbs_ack), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wb_xfer(1'b0, 16'h001C, 32'h0, lat, rd);
    check("ram_survives_reset", rd, 32'h7777_0007);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_frame_buffer_wb_slave.md
# led_frame_buffer_wb_slave

Wishbone responder that holds WS2812B LED frame data in an internal word RAM and serves the LED driver's single-word read cycles. A local fill port lets the pattern generator or CPU write pixel words, and that port has priority over Wishbone writes. The block sits between the frame-composition logic and the LED driver's memory-side Wishbone master.

## Interface

Parameters:

- ADDR_WIDTH, 16: Wishbone byte-address width.
- DATA_WIDTH, 32: word width. Must be a multiple of 8.
- DEPTH_WORDS, 256: RAM depth in words. Must be a power of two.
- BASE_ADDR, 0: byte address of word 0.
- Derived: IDX_WIDTH = clog2(DEPTH_WORDS); BSHIFT = clog2(DATA_WIDTH/8).

Ports:

- reset, input, 1: asynchronous, active-high reset.
- clk, input, 1: clock.
- wbs_address, input, ADDR_WIDTH: byte address. The low BSHIFT bits are ignored.
- wbs_writedata, input, DATA_WIDTH: write data.
- wbs_readdata, output, DATA_WIDTH: read data, registered. Valid while wbs_ack is high.
- wbs_strobe, input, 1: transfer request.
- wbs_cycle, input, 1: bus cycle active.
- wbs_write, input, 1: 1 selects write, 0 selects read.
- wbs_ack, output, 1: single-cycle acknowledge, registered.
- fill_we, input, 1: local write enable.
- fill_addr, input, IDX_WIDTH: local word index.
- fill_data, input, DATA_WIDTH: local write data.
- oor_flag, output, 1: sticky flag, set on any out-of-range Wishbone access.
- oor_clear, input, 1: synchronous clear of oor_flag.

## Operation

- Index calculation: idx = (wbs_address - BASE_ADDR) >> BSHIFT.
- An access is in range when wbs_address >= BASE_ADDR and idx < DEPTH_WORDS.
- The index is latched when a request is accepted in ST_IDLE.
- FSM states: ST_IDLE, ST_RD, ST_WR, ST_ACK.
  - ST_IDLE, with wbs_cycle & wbs_strobe:
    - Out of range: go to ST_ACK, load readdata with 0, set oor_flag.
    - In range, !wbs_write: go to ST_RD.
    - In range, wbs_write: go to ST_WR and latch writedata.
  - ST_RD: RAM is read at the latched index and the result is registered into wbs_readdata. Go to ST_ACK.
  - ST_WR: if fill_we is high, stay in ST_WR (fill has priority). Otherwise write the RAM at the latched index and go to ST_ACK.
  - ST_ACK: wbs_ack = 1 for exactly this cycle, then ST_IDLE unconditionally.
- Abort: wbs_cycle low in ST_RD or ST_WR returns the FSM to ST_IDLE. No ack is issued and no RAM write is performed.
- Fill port: when fill_we is high, RAM[fill_addr] <= fill_data on the same clock edge. The write applies in any state.
- RAM read behaviour is read-before-write. A fill write to the same index during ST_RD returns the old word.
- An out-of-range write is acknowledged and its data is discarded.
- oor_clear and a new out-of-range event in the same cycle: the set wins.
- RAM contents are not reset. The bench must initialise RAM before checking read data.

## Timing

- Reset values: wbs_ack = 0, wbs_readdata = 0, oor_flag = 0, state = ST_IDLE.
- Read latency, strobe first sampled at edge N:
  - State is ST_RD during cycle N+1.
  - wbs_ack and wbs_readdata are valid during cycle N+2.
- Write latency: ack is high during cycle N+2 plus one cycle per cycle in ST_WR with fill_we high.
- Out-of-range latency: ack is high during cycle N+1.
- wbs_readdata holds its value after ack until the next read or out-of-range access.
- The master must drop wbs_strobe no later than the cycle after ack. Because ST_ACK always returns to ST_IDLE, a strobe still high in that cycle is treated as a new request.
- Back-to-back throughput: at most one transfer per 3 cycles for in-range reads.
- Reset asserted mid-transfer: all outputs return to reset values immediately and no ack is issued. A RAM write is lost unless it was already clocked in.

## Test plan

- Fill RAM[5] = 0xA5A5_0001 via the fill port. A Wishbone read at address 0x0014 (BASE_ADDR = 0) gives ack exactly 2 cycles after strobe, with readdata = 0xA5A5_0001. Ack is one cycle wide.
- Wishbone write 0x1234_5678 to 0x0020, then read back 0x0020. Read returns 0x1234_5678. The write ack is 2 cycles after strobe.
- Wishbone write to idx 3 with fill_we held high for 3 cycles at fill_addr 9. The ack is delayed by 3 cycles, and both RAM[3] and RAM[9] are correct afterwards.
- Read at 0x0400 (idx 256, out of range). Ack is 1 cycle after strobe, readdata = 0, oor_flag = 1. Pulse oor_clear and oor_flag returns to 0.
- Deassert wbs_cycle while the FSM is in ST_WR (the write is held off by fill_we). No ack is issued, RAM is unchanged, and the FSM is back in ST_IDLE.
- Fill writes idx 7 in the same cycle as ST_RD for idx 7. Readdata returns the old word, and a subsequent read returns the new word.
